// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store engine: width codes, FSM states, lane helpers.
package mem_access_unit_pkg;

    localparam int unsigned NUM_LANES = 4;

    localparam logic [3:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [3:0] MEM_SEL_HALF = 4'b0011;
    localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Byte offset after dropping low bits below the access's natural alignment.
    function automatic logic [1:0] eff_offset(input logic [3:0] sel, input logic [1:0] off);
        logic [1:0] res;
        res = off;
        if (sel == MEM_SEL_WORD) begin
            res = 2'b00;
        end else if (sel == MEM_SEL_HALF) begin
            res = {off[1], 1'b0};
        end
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [3:0] sel, input logic [1:0] off);
        return ((sel == MEM_SEL_HALF) && off[0]) || ((sel == MEM_SEL_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: shift a RAM word down by byte offset, then mask and sign/zero-extend.
module mem_load_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_offset,
    input  logic [3:0]            i_sel,
    input  logic                  i_sign_ext,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = i_data >> {i_offset, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_sel)
            MEM_SEL_BYTE: o_data = {{(DATA_WIDTH-8){i_sign_ext & w_shifted[7]}}, w_shifted[7:0]};
            MEM_SEL_HALF: o_data = {{(DATA_WIDTH-16){i_sign_ext & w_shifted[15]}}, w_shifted[15:0]};
            default:      o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine driving a req/ready data RAM and stalling the pipeline.
// Define MEM_ADDR_CHECK_EN to flag misaligned half/word accesses instead of truncating them.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_mem_read_flag,
    input  logic                  i_mem_write_flag,
    input  logic                  i_mem_sign_ext_flag,
    input  logic [3:0]            i_mem_sel,
    input  logic [DATA_WIDTH-1:0] i_mem_write_data,
    input  logic [ADDR_WIDTH-1:0] i_addr_in,
    input  logic [DATA_WIDTH-1:0] i_result_in,
    input  logic                  i_flush,
    output logic                  o_ram_en,
    output logic [3:0]            o_ram_write_en,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_write_data,
    input  logic [DATA_WIDTH-1:0] i_ram_read_data,
    input  logic                  i_ram_ready,
    output logic                  o_stall_req,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_addr_error
);

    state_e                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_strb, r_sel;
    logic [DATA_WIDTH-1:0] r_wdata, r_buf;
    logic [1:0]            r_off;
    logic                  r_is_store, r_sign, r_flush;

    logic                  w_mem_op, w_addr_err, w_start;
    logic [1:0]            w_off;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_mem_op = i_mem_read_flag | i_mem_write_flag;
    assign w_off    = eff_offset(i_mem_sel, i_addr_in[1:0]);

`ifdef MEM_ADDR_CHECK_EN
    assign w_addr_err = w_mem_op && is_misaligned(i_mem_sel, i_addr_in[1:0]);
`else
    assign w_addr_err = 1'b0;
`endif

    assign w_start = (r_state == StIdle) && w_mem_op && !w_addr_err;

    assign o_ram_addr       = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign o_ram_write_data = r_wdata;

    mem_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .i_data     (r_buf),
        .i_offset   (r_off),
        .i_sel      (r_sel),
        .i_sign_ext (r_sign),
        .o_data     (w_load_data)
    );

    always_comb begin
        w_state_next   = r_state;
        o_stall_req    = 1'b0;
        o_ram_en       = 1'b0;
        o_ram_write_en = 4'b0000;
        o_addr_error   = 1'b0;
        o_result       = i_result_in;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = StReq;
                    o_stall_req  = 1'b1;
                end else if (w_addr_err) begin
                    o_addr_error = 1'b1;
                    o_result     = DATA_WIDTH'(i_addr_in);
                end
            end
            StReq: begin
                o_ram_en       = 1'b1;
                o_ram_write_en = r_strb;
                o_stall_req    = 1'b1;
                if (i_ram_ready) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                o_result     = r_is_store ? DATA_WIDTH'(r_addr) : w_load_data;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        // A flush seen mid-transaction only takes effect once the bus access completes.
        if ((i_flush && (r_state != StReq)) || ((r_state == StDone) && r_flush)) begin
            o_result = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_strb     <= 4'b0000;
            r_sel      <= 4'b0000;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_off      <= 2'b00;
            r_is_store <= 1'b0;
            r_sign     <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_addr     <= i_addr_in;
                r_strb     <= i_mem_write_flag ? 4'(i_mem_sel << w_off) : 4'b0000;
                r_sel      <= i_mem_sel;
                r_wdata    <= i_mem_write_data << {w_off, 3'b000};
                r_off      <= w_off;
                r_is_store <= i_mem_write_flag;
                r_sign     <= i_mem_sign_ext_flag;
                r_flush    <= 1'b0;
            end
            if (r_state == StReq) begin
                if (i_flush) begin
                    r_flush <= 1'b1;
                end
                if (i_ram_ready) begin
                    r_buf <= i_ram_read_data;
                end
            end
        end
    end

    a_no_read_and_write: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_mem_read_flag && i_mem_write_flag));

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;

`ifdef MEM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_flag, wr_flag, sx_flag, flush, ram_ready;
    logic [3:0]  sel;
    logic [31:0] wdata, addr_in, result_in, ram_rdata;
    logic        ram_en, stall, addr_err;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr, ram_wdata, result;

    mem_access_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_mem_read_flag     (rd_flag),
        .i_mem_write_flag    (wr_flag),
        .i_mem_sign_ext_flag (sx_flag),
        .i_mem_sel           (sel),
        .i_mem_write_data    (wdata),
        .i_addr_in           (addr_in),
        .i_result_in         (result_in),
        .i_flush             (flush),
        .o_ram_en            (ram_en),
        .o_ram_write_en      (ram_wen),
        .o_ram_addr          (ram_addr),
        .o_ram_write_data    (ram_wdata),
        .i_ram_read_data     (ram_rdata),
        .i_ram_ready         (ram_ready),
        .o_stall_req         (stall),
        .o_result            (result),
        .o_addr_error        (addr_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Current transaction as seen by the model
    bit          chk_en = 1'b0;
    int          cur_k, cur_w;
    bit          cur_mem, cur_err, exp_store;
    logic [31:0] exp_result, exp_addr_word, exp_wdata, lane_mask;
    logic [3:0]  exp_strb;

    // Observations for the literal checks
    int          obs_stall, obs_en_cnt;
    logic [31:0] obs_result, obs_addr, obs_wdata;
    logic [3:0]  obs_strb;
    bit          obs_err;

    bit e_stall, e_en;

    always @(negedge clk) begin
        if (chk_en) begin
            e_stall = cur_mem && !cur_err && (cur_k <= cur_w + 1);
            e_en    = cur_mem && !cur_err && (cur_k >= 1) && (cur_k <= cur_w + 1);
            check("stall_req", 32'(stall), 32'(e_stall));
            check("ram_en", 32'(ram_en), 32'(e_en));
            check("ram_write_en", 32'(ram_wen), (e_en && exp_store) ? 32'(exp_strb) : 32'h0);
            check("addr_error", 32'(addr_err), 32'(cur_err && (cur_k == 0)));
            if (e_en) begin
                check("ram_addr", ram_addr, exp_addr_word);
                if (exp_store) check("ram_write_data", ram_wdata & lane_mask, exp_wdata & lane_mask);
            end
            if (!e_stall) begin
                check("result", result, exp_result);
                obs_result = result;
            end
            if (stall) obs_stall++;
            if (addr_err) obs_err = 1'b1;
            if (ram_en) begin
                obs_en_cnt++;
                obs_strb  = ram_wen;
                obs_addr  = ram_addr;
                obs_wdata = ram_wdata;
            end
        end
    end

    // Called just after a rising edge; leaves just after a rising edge.
    task automatic run_op(input bit rd, input bit wr, input bit sg, input logic [3:0] s,
                          input logic [31:0] wd, input logic [31:0] a, input logic [31:0] rin,
                          input int w, input logic [31:0] rdata, input logic [31:0] fsched);
        logic [1:0]  off, eoff;
        logic [31:0] v, base;
        bit          flushed;
        int          len;
        off  = a[1:0];
        eoff = (s == 4'hF) ? 2'd0 : (s == 4'h3) ? {off[1], 1'b0} : off;
        cur_mem   = rd | wr;
        exp_store = wr;
        cur_err   = CHECK_EN && cur_mem && (((s == 4'h3) && off[0]) || ((s == 4'hF) && off != 2'd0));
        cur_w     = w;
        len       = (cur_mem && !cur_err) ? w + 3 : 1;
        if (!cur_mem) begin
            base = rin;
        end else if (cur_err || wr) begin
            base = a;
        end else begin
            v = rdata >> (8 * eoff);
            if (s == 4'h1) begin
                v = v % 256;
                if (sg && v >= 128) v = v + 32'hFFFFFF00;
            end else if (s == 4'h3) begin
                v = v % 65536;
                if (sg && v >= 32768) v = v + 32'hFFFF0000;
            end
            base = v;
        end
        flushed = 1'b0;
        if (len == 1) flushed = fsched[0];
        else for (int k = 1; k <= w + 2; k++) if (fsched[k]) flushed = 1'b1;
        exp_result    = flushed ? 32'h0 : base;
        exp_strb      = wr ? 4'(s << eoff) : 4'h0;
        exp_wdata     = wd << (8 * eoff);
        exp_addr_word = {a[31:2], 2'b00};
        for (int l = 0; l < 4; l++) lane_mask[8*l +: 8] = {8{exp_strb[l]}};
        rd_flag = rd; wr_flag = wr; sx_flag = sg; sel = s;
        wdata = wd; addr_in = a; result_in = rin;
        obs_stall = 0; obs_en_cnt = 0; obs_err = 1'b0;
        obs_strb = 4'h0; obs_result = 32'hx;
        chk_en = 1'b1;
        for (int k = 0; k < len; k++) begin
            cur_k = k;
            flush = fsched[k];
            if (len > 1 && k >= 1 && k <= w) begin
                ram_ready = 1'b0;
                ram_rdata = $urandom;
            end else if (len > 1 && k == w + 1) begin
                ram_ready = 1'b1;
                ram_rdata = rdata;
            end else begin
                ram_ready = 1'($urandom_range(0, 1));
                ram_rdata = $urandom;
            end
            @(posedge clk);
            #1;
        end
        chk_en = 1'b0;
        flush = 1'b0;
        ram_ready = 1'b0;
    endtask

    int          kind;
    logic [3:0]  rsel;
    logic [31:0] rflush;

    initial begin
        rst = 1'b1;
        {rd_flag, wr_flag, sx_flag, flush, ram_ready} = '0;
        sel = 4'h0; wdata = 0; addr_in = 0; result_in = 32'h77; ram_rdata = 0;
        #2;
        check("reset ram_en", 32'(ram_en), 32'h0);
        check("reset ram_write_en", 32'(ram_wen), 32'h0);
        check("reset ram_addr", ram_addr, 32'h0);
        check("reset ram_write_data", ram_wdata, 32'h0);
        check("reset addr_error", 32'(addr_err), 32'h0);
        check("reset stall_req", 32'(stall), 32'h0);
        check("reset result", result, 32'h77);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        run_op(0, 1, 0, 4'hF, 32'hDEADBEEF, 32'h100, 0, 0, 0, 0);
        check("sw stall cycles", 32'(obs_stall), 32'd2);
        check("sw result", obs_result, 32'h100);
        check("sw strobes", 32'(obs_strb), 32'hF);
        check("sw ram_addr", obs_addr, 32'h100);
        check("sw ram_write_data", obs_wdata, 32'hDEADBEEF);

        run_op(1, 0, 1, 4'h1, 0, 32'h203, 0, 3, 32'h80112233, 0);
        check("lb stall cycles", 32'(obs_stall), 32'd5);
        check("lb result", obs_result, 32'hFFFFFF80);
        check("lb strobes", 32'(obs_strb), 32'h0);
        check("lb ram_addr", obs_addr, 32'h200);

        run_op(1, 0, 0, 4'h1, 0, 32'h203, 0, 3, 32'h80112233, 0);
        check("lbu result", obs_result, 32'h00000080);

        run_op(0, 1, 0, 4'h3, 32'h0000ABCD, 32'h0A, 0, 0, 0, 0);
        check("sh strobes", 32'(obs_strb), 32'hC);
        check("sh ram_write_data", obs_wdata, 32'hABCD0000);
        check("sh ram_addr", obs_addr, 32'h08);

        run_op(0, 0, 0, 4'h0, 0, 32'h5, 32'h1234, 0, 0, 0);
        check("alu stall cycles", 32'(obs_stall), 32'd0);
        check("alu result", obs_result, 32'h1234);
        check("alu ram_en cycles", 32'(obs_en_cnt), 32'd0);

        run_op(1, 0, 0, 4'hF, 0, 32'h40, 0, 2, 32'h55, 32'h4);
        check("flush ram_en cycles", 32'(obs_en_cnt), 32'd3);
        check("flush result", obs_result, 32'h0);

`ifdef MEM_ADDR_CHECK_EN
        run_op(1, 0, 0, 4'hF, 0, 32'h102, 0, 0, 0, 0);
        check("misaligned addr_error", 32'(obs_err), 32'h1);
        check("misaligned ram_en cycles", 32'(obs_en_cnt), 32'd0);
        check("misaligned result", obs_result, 32'h102);
`endif

        // Reset while a load is waiting on the bus
        rd_flag = 1'b1; wr_flag = 1'b0; sel = 4'hF; addr_in = 32'h80; ram_ready = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        check("pre-reset ram_en", 32'(ram_en), 32'h1);
        rst = 1'b1;
        #1;
        check("mid reset ram_en", 32'(ram_en), 32'h0);
        check("mid reset ram_write_en", 32'(ram_wen), 32'h0);
        rd_flag = 1'b0; result_in = 32'h99;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post reset stall_req", 32'(stall), 32'h0);
        check("post reset result", result, 32'h99);
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 2))
                0:       rsel = 4'h1;
                1:       rsel = 4'h3;
                default: rsel = 4'hF;
            endcase
            rflush = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 7)) : 32'h0;
            run_op(kind == 0, kind == 1, 1'($urandom_range(0, 1)), rsel, $urandom, $urandom,
                   $urandom, $urandom_range(0, 5), $urandom, rflush);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine. It consumes the memory-side outputs of EX: read/write/sign-ext flags, byte select, store data, and the ALU result as the address.
- Drives a request/ready data-RAM bus and stalls the pipeline until the access completes.
- Returns aligned, sign- or zero-extended load data to WB. Non-memory instructions pass through in zero cycles.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; fixed 4 byte lanes, little-endian

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mem_read_flag  in  1  load from EX
mem_write_flag  in  1  store from EX
mem_sign_ext_flag  in  1  sign-extend sub-word load
mem_sel  in  4  width code: 0001 byte, 0011 half, 1111 word (unshifted)
mem_write_data  in  DATA_WIDTH  store data, right-aligned
addr_in  in  ADDR_WIDTH  EX result used as address
result_in  in  DATA_WIDTH  EX result for non-memory ops
flush  in  1  discard current instruction's writeback
ram_en  out  1  bus request
ram_write_en  out  4  byte write strobes
ram_addr  out  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}
ram_write_data  out  DATA_WIDTH  lane-shifted store data
ram_read_data  in  DATA_WIDTH  read data, valid with ram_ready
ram_ready  in  1  transaction complete
stall_req  out  1  hold upstream stages
result  out  DATA_WIDTH  to WB
addr_error  out  1  misaligned access (optional feature)

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset (async) → IDLE. At reset ram_en=0, ram_write_en=0, ram_addr=0, ram_write_data=0, load buffer=0, addr_error=0.
- IDLE with (read|write) and no error: latch addr, lane strobes, shifted data, op type, sign-ext, byte offset. Go to REQ. stall_req=1 (combinational).
- IDLE with no memory op: result=result_in, stall_req=0.
- REQ: ram_en=1. ram_write_en = (mem_sel<<addr[1:0]) for stores, 0 for loads. stall_req=1.
  - Outputs are held constant until ram_ready is sampled high.
  - On ram_ready: capture ram_read_data into the load buffer, go to DONE.
- DONE: stall_req=0, ram_en=0.
  - Load: result = buffer>>(8*offset), masked to width, then sign- or zero-extended.
  - Store: result = latched addr.
  - Next state is always IDLE. A new op is not accepted in DONE; it is detected in the following IDLE cycle.
- Upstream inputs are stable while stall_req=1.
- Latency: zero-wait RAM (ram_ready in the first REQ cycle) gives 2 stall cycles. Each extra ready-low cycle adds 1.
- Store lane shift: ram_write_data = mem_write_data << (8*addr[1:0]). Byte and half are replicated as needed.
- Read if both flags are set: treated as store. The flag pair is illegal from ID and is flagged by an assertion.
- ram_ready while not in REQ: ignored.
- flush in REQ: the bus transaction still completes and is not aborted. A sticky flag is set; in DONE result is forced to 0.
- flush in IDLE/DONE: result forced to 0 that cycle.
- Reset mid-transaction: immediate return to IDLE; the RAM side must tolerate a dropped request.

Optional Feature:
- Macro MEM_ADDR_CHECK_EN.
- Defined:
  - half with addr[0]≠0, or word with addr[1:0]≠0, asserts addr_error combinationally in IDLE.
  - No bus request is made, stall_req=0, result=addr_in (BadVAddr for CP0).
- Undefined:
  - addr_error tied 0; low address bits silently truncated to the natural alignment.

Decomposition:
- Shared package/header (alongside bus.v): MEM_SEL_BYTE/HALF/WORD codes, FSM state encodings, byte-lane count.
- One sub-module, mem_load_align: combinational shift, mask and extend of the load buffer by offset, width and sign. Reusable by an LL/LWL path later.

Test Plan:
- Word store, addr 0x100, data 0xDEADBEEF, ready 1 cycle after ram_en → ram_write_en=1111, ram_addr=0x100, stall_req high for 2 cycles, result=0x100.
- Byte load signed, addr 0x203, RAM returns 0x80112233 after 3 wait cycles → ram_write_en=0000, stall 5 cycles, result=0xFFFFFF80. Unsigned variant gives 0x00000080.
- Half store, addr 0x0A, data 0x0000ABCD → ram_write_en=1100, ram_write_data=0xABCD0000.
- Non-memory op, result_in=0x1234 → stall_req=0, result=0x1234 same cycle, ram_en=0.
- flush during REQ of a load, ready returns 0x55 → ram_en held until ready, DONE result=0. Separately, rst asserted in REQ → ram_en=0 immediately, state IDLE.
- With MEM_ADDR_CHECK_EN: word load at 0x102 → addr_error=1, ram_en never asserted, result=0x102.
